// File: rtl/branch_tracker_pkg.sv
// -----------------------------------------------------------------------------
// branch_tracker_pkg
// Shared definitions for the branch tracker slice:
//   - AddressWidth   : machine address width shared with fetch/decode
//   - BT_DEPTH       : default number of in-flight branches (power of two)
//   - BT_TAG_W       : default tag width, log2(BT_DEPTH)
//   - ent_state_e    : per-entry lifecycle encoding
//   - bt_next_pc()   : architectural next PC of a resolved branch
// -----------------------------------------------------------------------------
package branch_tracker_pkg;

  localparam int AddressWidth = 32;
  localparam int BT_DEPTH     = 8;
  localparam int BT_TAG_W     = 3;

  // Entry lifecycle: EMPTY -> PENDING (allocate) -> RESOLVED (resolve) -> EMPTY
  typedef enum logic [1:0] {
    ENT_EMPTY    = 2'b00,
    ENT_PENDING  = 2'b01,
    ENT_RESOLVED = 2'b10
  } ent_state_e;

  // Taken branches continue at their target, fall-through continues at pc+4.
  // The add wraps naturally at AddressWidth bits.
  function automatic logic [AddressWidth-1:0] bt_next_pc(
    input logic [AddressWidth-1:0] pc,
    input logic                    taken,
    input logic [AddressWidth-1:0] target
  );
    return taken ? target : (pc + AddressWidth'(4));
  endfunction

endpackage

// File: rtl/branch_tracker_if.sv
// -----------------------------------------------------------------------------
// branch_tracker_if
// Groups the decoder allocate port, the branch ALU resolve port and the
// tracker's outputs (allocation tag/full, predictor training, flush/redirect).
//
// Handshake semantics (single place of documentation):
//   - dec_alloc_en_in is a request; it is accepted at a rising edge only when
//     bt_full_out is low and the global ready is high. bt_alloc_tag_out is the
//     tag the request receives. A request presented while full is dropped and
//     the decoder must hold it until bt_full_out falls. An accepted allocate in
//     the same cycle as a flush is discarded with everything else.
//   - ex_res_en_in has no back-pressure; it is consumed only when the tagged
//     entry is PENDING, otherwise silently ignored.
//   - bt_bp_en_out and bt_flush_out are single-cycle strobes; their data
//     (bt_bp_pc_out/bt_bp_correct_out, bt_redirect_pc_out) hold between strobes.
//
// Modports:
//   slave  : the tracker side
//   master : the pipeline side (decoder + branch ALU + fetch + predictor)
// bt_dbg_state_out exposes the per-entry state, 2 bits per entry.
// -----------------------------------------------------------------------------
interface branch_tracker_if
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH  = BT_DEPTH,
  parameter int TAG_W  = BT_TAG_W,
  parameter int ADDR_W = AddressWidth
) ();

  logic              dec_alloc_en_in;
  logic [ADDR_W-1:0] dec_alloc_pc_in;
  logic              dec_alloc_taken_in;
  logic [TAG_W-1:0]  bt_alloc_tag_out;
  logic              bt_full_out;

  logic              ex_res_en_in;
  logic [TAG_W-1:0]  ex_res_tag_in;
  logic              ex_res_taken_in;
  logic [ADDR_W-1:0] ex_res_target_in;

  logic              bt_bp_en_out;
  logic              bt_bp_correct_out;
  logic [ADDR_W-1:0] bt_bp_pc_out;
  logic              bt_flush_out;
  logic [ADDR_W-1:0] bt_redirect_pc_out;

  logic [2*DEPTH-1:0] bt_dbg_state_out;

  modport slave (
    input  dec_alloc_en_in, dec_alloc_pc_in, dec_alloc_taken_in,
    input  ex_res_en_in, ex_res_tag_in, ex_res_taken_in, ex_res_target_in,
    output bt_alloc_tag_out, bt_full_out,
    output bt_bp_en_out, bt_bp_correct_out, bt_bp_pc_out,
    output bt_flush_out, bt_redirect_pc_out,
    output bt_dbg_state_out
  );

  modport master (
    output dec_alloc_en_in, dec_alloc_pc_in, dec_alloc_taken_in,
    output ex_res_en_in, ex_res_tag_in, ex_res_taken_in, ex_res_target_in,
    input  bt_alloc_tag_out, bt_full_out,
    input  bt_bp_en_out, bt_bp_correct_out, bt_bp_pc_out,
    input  bt_flush_out, bt_redirect_pc_out,
    input  bt_dbg_state_out
  );

endinterface

// File: rtl/branch_tracker_ptr_ctl.sv
// -----------------------------------------------------------------------------
// bt_ptr_ctl
// Head/tail/count bookkeeping of the branch tracker circular buffer.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   rdy_in           : global ready, pointers frozen when low
//   i_alloc          : an allocate is written at the tail this cycle
//   i_retire         : the head entry retires this cycle
//   i_flush          : misprediction; pointers and count return to zero
//   o_head, o_tail   : oldest entry / next allocation slot
//   o_full           : count == DEPTH (from the registered count)
// -----------------------------------------------------------------------------
module bt_ptr_ctl #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             i_alloc,
  input  logic             i_retire,
  input  logic             i_flush,
  output logic [TAG_W-1:0] o_head,
  output logic [TAG_W-1:0] o_tail,
  output logic             o_full
);

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic [TAG_W:0]   w_alloc_ext;
  logic [TAG_W:0]   w_retire_ext;

  assign w_alloc_ext  = {{TAG_W{1'b0}}, i_alloc};
  assign w_retire_ext = {{TAG_W{1'b0}}, i_retire};

  // Pointers wrap modulo DEPTH through natural TAG_W-bit overflow.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + w_retire_ext[TAG_W-1:0];
        r_tail  <= r_tail + w_alloc_ext[TAG_W-1:0];
        r_count <= r_count + w_alloc_ext - w_retire_ext;
      end
    end
  end

  assign o_head = r_head;
  assign o_tail = r_tail;
  assign o_full = (r_count == (TAG_W+1)'(DEPTH));

endmodule

// File: rtl/branch_tracker.sv
// -----------------------------------------------------------------------------
// branch_tracker
// In-order tracker for predicted conditional branches. Branches are recorded
// at decode, resolved out of order by the branch ALU, retired in program order
// to train the predictor, and a mispredicting retire raises a one-cycle flush
// with the corrected fetch PC.
//
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   rdy_in   : global ready, all state frozen and strobes cleared when low
//   bt_if    : branch_tracker_if.slave (allocate, resolve, training, flush)
//
// Build option:
//   BT_RESOLVE_BYPASS_EN - when defined, a resolve of the PENDING head retires
//   at the same edge using the resolve inputs directly, one cycle earlier.
// -----------------------------------------------------------------------------
module branch_tracker
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH  = BT_DEPTH,
  parameter int TAG_W  = BT_TAG_W,
  parameter int ADDR_W = AddressWidth
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  branch_tracker_if.slave   bt_if
);

  logic [TAG_W-1:0]  w_head;
  logic [TAG_W-1:0]  w_tail;
  logic              w_full;

  ent_state_e        r_state     [DEPTH];
  ent_state_e        w_state_nxt [DEPTH];
  logic [ADDR_W-1:0] r_pc        [DEPTH];
  logic              r_pred      [DEPTH];
  logic              r_act_taken [DEPTH];
  logic [ADDR_W-1:0] r_act_next  [DEPTH];

  logic              r_bp_en;
  logic              r_bp_correct;
  logic [ADDR_W-1:0] r_bp_pc;
  logic              r_flush;
  logic [ADDR_W-1:0] r_redirect;

  logic              w_alloc;
  logic              w_res_hit;
  logic              w_head_resolved;
  logic              w_bypass;
  logic              w_retire;
  logic              w_ret_act_taken;
  logic [ADDR_W-1:0] w_ret_act_next;
  logic              w_ret_correct;
  logic              w_flush;
  logic              w_res_take;
  logic              w_alloc_take;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_alloc         = bt_if.dec_alloc_en_in && !w_full && rdy_in;
  assign w_res_hit       = bt_if.ex_res_en_in && rdy_in &&
                           (r_state[bt_if.ex_res_tag_in] == ENT_PENDING);
  assign w_head_resolved = (r_state[w_head] == ENT_RESOLVED);

`ifdef BT_RESOLVE_BYPASS_EN
  // A resolve aimed at the PENDING head retires straight away.
  assign w_bypass = w_res_hit && (bt_if.ex_res_tag_in == w_head);
`else
  assign w_bypass = 1'b0;
`endif

  // The head is either RESOLVED or bypassed, never both (bypass needs PENDING).
  assign w_retire        = rdy_in && (w_head_resolved || w_bypass);
  assign w_ret_act_taken = w_bypass ? bt_if.ex_res_taken_in : r_act_taken[w_head];
  assign w_ret_act_next  = w_bypass ? bt_next_pc(r_pc[w_head], bt_if.ex_res_taken_in,
                                                 bt_if.ex_res_target_in)
                                    : r_act_next[w_head];
  assign w_ret_correct   = (r_pred[w_head] == w_ret_act_taken);
  assign w_flush         = w_retire && !w_ret_correct;

  // A flush discards anything else presented in the same cycle.
  assign w_res_take      = w_res_hit && !w_flush && !w_bypass;
  assign w_alloc_take    = w_alloc && !w_flush;

  // ---------------------------------------------------------------------------
  // Pointer control
  // ---------------------------------------------------------------------------
  bt_ptr_ctl #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ptr_ctl (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .i_alloc  (w_alloc_take),
    .i_retire (w_retire),
    .i_flush  (w_flush),
    .o_head   (w_head),
    .o_tail   (w_tail),
    .o_full   (w_full)
  );

  // ---------------------------------------------------------------------------
  // Per-entry state machines: next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_flush) begin
        w_state_nxt[i] = ENT_EMPTY;
      end else begin
        // Retire targets the head, allocate the (empty) tail, resolve a
        // PENDING entry; these never address the same entry at once.
        if (w_retire && (w_head == TAG_W'(i))) begin
          w_state_nxt[i] = ENT_EMPTY;
        end
        if (w_alloc_take && (w_tail == TAG_W'(i))) begin
          w_state_nxt[i] = ENT_PENDING;
        end
        if (w_res_take && (bt_if.ex_res_tag_in == TAG_W'(i))) begin
          w_state_nxt[i] = ENT_RESOLVED;
        end
      end
    end
  end

  // Per-entry state machines: state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ENT_EMPTY;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload; only meaningful while the entry is not EMPTY, so no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_alloc_take) begin
      r_pc[w_tail]   <= bt_if.dec_alloc_pc_in;
      r_pred[w_tail] <= bt_if.dec_alloc_taken_in;
    end
    if (w_res_take) begin
      r_act_taken[bt_if.ex_res_tag_in] <= bt_if.ex_res_taken_in;
      r_act_next[bt_if.ex_res_tag_in]  <= bt_next_pc(r_pc[bt_if.ex_res_tag_in],
                                                     bt_if.ex_res_taken_in,
                                                     bt_if.ex_res_target_in);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered retire / flush outputs. w_retire already includes rdy_in, so
  // the strobes clear at any edge where the tracker is stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_bp_en      <= 1'b0;
      r_bp_correct <= 1'b0;
      r_bp_pc      <= '0;
      r_flush      <= 1'b0;
      r_redirect   <= '0;
    end else begin
      r_bp_en <= w_retire;
      r_flush <= w_flush;
      if (w_retire) begin
        r_bp_pc      <= r_pc[w_head];
        r_bp_correct <= w_ret_correct;
      end
      if (w_flush) begin
        r_redirect <= w_ret_act_next;
      end
    end
  end

  assign bt_if.bt_alloc_tag_out   = w_tail;
  assign bt_if.bt_full_out        = w_full;
  assign bt_if.bt_bp_en_out       = r_bp_en;
  assign bt_if.bt_bp_correct_out  = r_bp_correct;
  assign bt_if.bt_bp_pc_out       = r_bp_pc;
  assign bt_if.bt_flush_out       = r_flush;
  assign bt_if.bt_redirect_pc_out = r_redirect;

  always_comb begin
    bt_if.bt_dbg_state_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bt_if.bt_dbg_state_out[2*i +: 2] = r_state[i];
    end
  end

endmodule

// File: tb/tb_branch_tracker.sv
// -----------------------------------------------------------------------------
// tb_branch_tracker
// Directed scenarios followed by randomized traffic, checked every cycle
// against an in-order queue model of the tracker. Retired PCs are also
// tracked through an expected-value queue.
// -----------------------------------------------------------------------------
module tb_branch_tracker;
  import branch_tracker_pkg::*;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int ADDR_W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;

  always #5 clk = ~clk;

  branch_tracker_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) bt_if ();

  branch_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bt_if    (bt_if.slave)
  );

  // ---------------------------------------------------------------------------
  // Reference model: list of in-flight branches, oldest first
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] pc;
    logic              pred;
    logic              done;
    logic              act;
    logic [ADDR_W-1:0] nxt;
  } m_ent_t;

  m_ent_t            m_q[$];
  int                m_tail;
  logic              m_bp_en, m_flush, m_correct;
  logic [ADDR_W-1:0] m_bp_pc, m_redirect;

  logic [ADDR_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_tail     = 0;
    m_bp_en    = 1'b0;
    m_flush    = 1'b0;
    m_correct  = 1'b0;
    m_bp_pc    = '0;
    m_redirect = '0;
  endtask

  // One clock edge of the tracker described as operations on the list.
  task automatic model_step();
    bit                full;
    bit                ret;
    bit                act;
    logic [ADDR_W-1:0] nxt;
    m_ent_t            e;
    m_bp_en = 1'b0;
    m_flush = 1'b0;
    if (!rdy) return;
    full = (m_q.size() == DEPTH);
    ret  = 1'b0;
    act  = 1'b0;
    nxt  = '0;
    if (m_q.size() > 0) begin
      if (m_q[0].done) begin
        ret = 1'b1;
        act = m_q[0].act;
        nxt = m_q[0].nxt;
      end
`ifdef BT_RESOLVE_BYPASS_EN
      else if (bt_if.ex_res_en_in && bt_if.ex_res_tag_in == m_q[0].tag) begin
        ret = 1'b1;
        act = bt_if.ex_res_taken_in;
        nxt = act ? bt_if.ex_res_target_in : m_q[0].pc + 32'd4;
      end
`endif
    end
    if (ret) begin
      m_bp_en   = 1'b1;
      m_bp_pc   = m_q[0].pc;
      m_correct = (m_q[0].pred == act);
      exp_q.push_back(m_q[0].pc);
      if (!m_correct) begin
        m_flush    = 1'b1;
        m_redirect = nxt;
        m_q.delete();
        m_tail = 0;
        return;
      end
      m_q.delete(0);
    end
    if (bt_if.ex_res_en_in) begin
      foreach (m_q[k]) begin
        if (m_q[k].tag == bt_if.ex_res_tag_in && !m_q[k].done) begin
          m_q[k].done = 1'b1;
          m_q[k].act  = bt_if.ex_res_taken_in;
          m_q[k].nxt  = bt_if.ex_res_taken_in ? bt_if.ex_res_target_in
                                              : m_q[k].pc + 32'd4;
        end
      end
    end
    if (bt_if.dec_alloc_en_in && !full) begin
      e.tag  = TAG_W'(m_tail);
      e.pc   = bt_if.dec_alloc_pc_in;
      e.pred = bt_if.dec_alloc_taken_in;
      e.done = 1'b0;
      e.act  = 1'b0;
      e.nxt  = '0;
      m_q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic compare_outputs();
    logic [ADDR_W-1:0] exp_pc;
    check("bp_en",    bt_if.bt_bp_en_out,       m_bp_en);
    check("flush",    bt_if.bt_flush_out,       m_flush);
    check("bp_pc",    bt_if.bt_bp_pc_out,       m_bp_pc);
    check("correct",  bt_if.bt_bp_correct_out,  m_correct);
    check("redirect", bt_if.bt_redirect_pc_out, m_redirect);
    check("full",     bt_if.bt_full_out,        (m_q.size() == DEPTH));
    check("tag",      bt_if.bt_alloc_tag_out,   m_tail);
    if (bt_if.bt_bp_en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_retire", 1, 0);
      end else begin
        exp_pc = exp_q.pop_front();
        check("sb_retire_pc", bt_if.bt_bp_pc_out, exp_pc);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    bt_if.dec_alloc_en_in    = 1'b0;
    bt_if.dec_alloc_pc_in    = '0;
    bt_if.dec_alloc_taken_in = 1'b0;
    bt_if.ex_res_en_in       = 1'b0;
    bt_if.ex_res_tag_in      = '0;
    bt_if.ex_res_taken_in    = 1'b0;
    bt_if.ex_res_target_in   = '0;
  endtask

  task automatic drive_alloc(input logic [ADDR_W-1:0] pc, input logic pred);
    bt_if.dec_alloc_en_in    = 1'b1;
    bt_if.dec_alloc_pc_in    = pc;
    bt_if.dec_alloc_taken_in = pred;
  endtask

  task automatic drive_res(input logic [TAG_W-1:0] tag, input logic taken,
                           input logic [ADDR_W-1:0] target);
    bt_if.ex_res_en_in     = 1'b1;
    bt_if.ex_res_tag_in    = tag;
    bt_if.ex_res_taken_in  = taken;
    bt_if.ex_res_target_in = target;
  endtask

  task automatic idle_ticks(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Resolve remaining entries correctly (taken == pred) until the list drains.
  task automatic drain();
    int cnt;
    cnt = 0;
    while (m_q.size() > 0 && cnt < 64) begin
      idle();
      foreach (m_q[k]) begin
        if (!m_q[k].done && !bt_if.ex_res_en_in) begin
          drive_res(m_q[k].tag, m_q[k].pred, 32'h4000 + 32'(k * 16));
        end
      end
      tick();
      cnt++;
    end
    idle_ticks(2);
    check("drain_done", m_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [TAG_W-1:0] t0, t3;
    int               cand[$];
    int               pick;

    idle();
    model_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_full", bt_if.bt_full_out, 0);
    check("rst_dbg",  bt_if.bt_dbg_state_out, 0);
    #2 rst_n = 1'b1;
    idle_ticks(1);

    // Correct taken prediction retires with training only
    drive_alloc(32'h100, 1'b1); tick();
    idle(); drive_res(3'd0, 1'b1, 32'h200); tick();
    idle_ticks(3);
    check("t1_pc",      bt_if.bt_bp_pc_out, 32'h100);
    check("t1_correct", bt_if.bt_bp_correct_out, 1);

    // Misprediction: flush, redirect to target, pointers back to 0
    drive_alloc(32'h104, 1'b0); tick();
    idle(); drive_res(3'd1, 1'b1, 32'h80); tick();
    idle_ticks(3);
    check("t2_redirect", bt_if.bt_redirect_pc_out, 32'h80);
    check("t2_tag",      bt_if.bt_alloc_tag_out, 0);
    check("t2_correct",  bt_if.bt_bp_correct_out, 0);

    // Out-of-order resolve, in-order retire
    for (int i = 0; i < 3; i++) begin
      drive_alloc(32'h1000 + 32'(i * 4), 1'b1); tick();
    end
    idle(); drive_res(3'd2, 1'b1, 32'h3000); tick();
    idle(); drive_res(3'd1, 1'b1, 32'h3000); tick();
    idle(); drive_res(3'd0, 1'b1, 32'h3000); tick();
    idle_ticks(5);

    // Fill, over-allocate, then retire while allocating at full
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(32'h2000 + 32'(i * 4), 1'b0); tick();
    end
    check("t4_full", bt_if.bt_full_out, 1);
    drive_alloc(32'h2ff0, 1'b0); tick();
    check("t4_full_9th", bt_if.bt_full_out, 1);
    idle(); drive_res(m_q[0].tag, 1'b0, 32'h0); tick();
    idle(); drive_alloc(32'h2ff4, 1'b0); tick();
    idle(); drive_alloc(32'h2ff8, 1'b0); tick();
    idle_ticks(1);
    drain();

    // Flush drops a same-cycle resolve and allocate; stale tag ignored later
    t0 = TAG_W'(m_tail);
    t3 = t0 + 3'd3;
    for (int i = 0; i < 5; i++) begin
      drive_alloc(32'h5000 + 32'(i * 4), 1'b1); tick();
    end
    idle(); drive_res(t0, 1'b0, 32'h0); tick();
    idle(); drive_res(t3, 1'b1, 32'h6000); drive_alloc(32'h5100, 1'b1); tick();
    idle_ticks(1);
    drive_res(t3, 1'b1, 32'h6000); tick();
    idle_ticks(3);
    drain();

    // Stall with a resolved head
    drive_alloc(32'h7000, 1'b1); tick();
    idle(); drive_res(m_q[0].tag, 1'b1, 32'h7100); tick();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rdy = 1'b1;
    tick();
    idle_ticks(3);

    // Randomized traffic with an asynchronous reset in the middle
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_alloc({$urandom_range(0, 32'hffff), 2'b00}, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) < 6) begin
        cand.delete();
        foreach (m_q[k]) if (!m_q[k].done) cand.push_back(k);
        if (cand.size() > 0 && $urandom_range(0, 9) < 8) begin
          pick = cand[$urandom_range(0, cand.size() - 1)];
          drive_res(m_q[pick].tag,
                    ($urandom_range(0, 9) < 8) ? m_q[pick].pred : !m_q[pick].pred,
                    {$urandom_range(0, 32'hffff), 2'b00});
        end else begin
          drive_res(TAG_W'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)),
                    {$urandom_range(0, 32'hffff), 2'b00});
        end
      end
      if (cyc == 1000) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_bp_en", bt_if.bt_bp_en_out, 0);
        check("async_rst_full",  bt_if.bt_full_out, 0);
        check("async_rst_tag",   bt_if.bt_alloc_tag_out, 0);
        check("async_rst_pc",    bt_if.bt_bp_pc_out, 0);
        check("async_rst_dbg",   bt_if.bt_dbg_state_out, 0);
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    rdy = 1'b1;
    idle_ticks(2);
    drain();
    check("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard time bound in case anything stalls the stimulus process.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    n_fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
